// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
// Build option: SEQ_DET_REG_OUT_EN registers the match pulse in seq_detect_ctrl.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_PAT_W = 4;
    localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/seq_det_core.sv
// Detect datapath: bit history, fill counter and masked pattern comparator.
// hit is combinational and only asserts on a cycle where shift is high.
module seq_det_core #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    localparam int unsigned HIST_W = PAT_W - 1;

    logic [HIST_W-1:0] hist_q;
    logic [LEN_W-1:0]  fill_q;
    logic [PAT_W-1:0]  window;
    logic [PAT_W-1:0]  mask;
    logic              filled;

    // Window is the history plus the bit arriving this cycle; mask keeps the low len bits.
    always_comb begin
        window = {hist_q, in};
        mask   = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        filled = ((LEN_W + 1)'(fill_q) + (LEN_W + 1)'(1)) >= (LEN_W + 1)'(len);
        hit    = shift & filled & (((window ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift) begin
            hist_q <= window[HIST_W-1:0];
            if (fill_q != LEN_W'(PAT_W)) begin
                fill_q <= fill_q + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time controller for the programmable sequence detector: config, FSM, match count.
// Build option: define SEQ_DET_REG_OUT_EN for a registered (one-cycle-late) match pulse.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned LEN_W = $clog2(PAT_W) + 1,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [CNT_W-1:0] lim_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             core_clr, core_shift, hit;
    logic             cfg_ok;
    logic [LEN_W-1:0] len_sel;

    seq_det_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (core_clr),
        .shift   (core_shift),
        .in      (in),
        .pattern (pat_q),
        .len     (len_q),
        .hit     (hit)
    );

    // Out-of-range lengths fall back to the full pattern width.
    always_comb begin
        cfg_ok  = (state_q == IDLE) || (state_q == DONE);
        len_sel = cfg_len;
        if ((cfg_len == '0) || (cfg_len > LEN_W'(PAT_W))) begin
            len_sel = LEN_W'(PAT_W);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= '0;
            len_q <= LEN_W'(PAT_W);
            ovl_q <= 1'b1;
            lim_q <= '0;
        end else if (cfg_we && cfg_ok) begin
            pat_q <= cfg_pattern;
            len_q <= len_sel;
            ovl_q <= cfg_overlap;
            lim_q <= cfg_limit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter update and datapath sequencing; stop outranks start and limit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        core_clr   = 1'b0;
        core_shift = 1'b0;
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            end
            ARM: begin
                core_clr = 1'b1;
                state_d  = stop ? IDLE : RUN;
            end
            RUN: begin
                core_shift = in_valid;
                if (hit) begin
                    cnt_d = cnt_inc;
                    if (!ovl_q) begin
                        core_clr = 1'b1;
                    end
                end
                if (stop) begin
                    state_d = IDLE;
                end else if (hit && (lim_q != '0) && (cnt_inc == lim_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SEQ_DET_REG_OUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= 1'b0;
        end else begin
            out <= hit;
        end
    end
`else
    assign out = hit;
`endif

    assign match_cnt = cnt_q;
    assign busy      = (state_q == ARM) || (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run-time controller for a programmable serial sequence detector. It generalises the fixed 1011 Mealy detector, with these additions:
- software-loaded pattern and pattern length
- selectable overlap or non-overlap matching
- match counting with an optional stop limit
- a start/stop control FSM
Sits between the config/control interface and the serial bit stream, sequencing the detect datapath (seq_det_core).

Parameters:
PAT_W, 4, maximum pattern length in bits (>=2)
LEN_W, $clog2(PAT_W)+1, width of the length field
CNT_W, 8, width of the match counter and limit

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
cfg_we  input  1  load cfg_* registers (honoured only in IDLE or DONE)
cfg_pattern  input  PAT_W  pattern; bit [len-1] is the first bit received
cfg_len  input  LEN_W  pattern length in bits, legal range 1..PAT_W
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_limit  input  CNT_W  stop after this many matches; 0 = unlimited
start  input  1  begin a detection run
stop  input  1  abort the run
in_valid  input  1  serial bit qualifier
in  input  1  serial data bit
out  output  1  match pulse (Mealy: same cycle as the last pattern bit)
match_cnt  output  CNT_W  matches in the current/last run
busy  output  1  state is ARM or RUN
done  output  1  state is DONE

Behaviour:
Reset (rst=0, asynchronous):
- state IDLE; out=0, match_cnt=0, busy=0, done=0
- pattern=0, len=PAT_W, overlap=1, limit=0
- history and fill counter cleared

States: IDLE, ARM, RUN, DONE.
- IDLE: start=1 -> ARM; clears match_cnt. If stop=1 in the same cycle, stop wins and the FSM stays in IDLE.
- ARM: exactly one cycle. History and fill counter are cleared and input is ignored. Goes to RUN, or to IDLE if stop=1.
- RUN: each cycle with in_valid=1, history shifts left with `in` entering at the LSB. The fill counter increments, saturating at PAT_W. Cycles with in_valid=0 change nothing.
- Match condition (RUN only): in_valid=1, fill >= len-1, and {history[len-2:0], in} == pattern[len-1:0]. For len=1, the condition is in == pattern[0].
  - out is combinational and equals the match condition; it is 0 in every other state.
- On a match:
  - match_cnt increments, saturating at all-ones.
  - overlap=1: history keeps shifting normally.
  - overlap=0: the fill counter is cleared on that edge, so no bits are reused.
- Limit: if limit != 0 and the incremented count equals limit -> DONE on that edge.
- stop=1 in RUN -> IDLE next edge; match_cnt is held.
  - A match in the same cycle still pulses out and is counted, then the FSM goes to IDLE.
  - Stop has priority over the limit transition.
- DONE: done=1, input is ignored, match_cnt is held. start -> ARM (count cleared); stop -> IDLE.
- cfg_we while busy is ignored. A cfg_len of 0 or greater than PAT_W is latched as PAT_W.
- Reset asserted mid-run returns every register to its reset value immediately. No match is reported.

Optional Feature:
SEQ_DET_REG_OUT_EN
- Defined: out is registered; it rises one clk after the match bit, is a 1-cycle pulse, and resets to 0. match_cnt and FSM timing are unchanged.
- Undefined: out is the combinational Mealy output described above.

Decomposition:
- Package seq_det_pkg holds:
  - state encoding constants (IDLE=2'd0, ARM=2'd1, RUN=2'd2, DONE=2'd3)
  - default PAT_W and CNT_W
- Sub-module seq_det_core holds the history shift register, fill counter and comparator. Its inputs are clr, shift, in, pattern, len; its output is hit.
- seq_detect_ctrl holds the FSM, config registers and counter.

Test Plan:
1. Overlap match: cfg pattern=4'b1011, len=4, overlap=1, limit=0; start; stream 0,0,1,0,1,1,0,1,1,1,1,0,1,1,0 with in_valid=1 -> out pulses on bits 6, 9 and 14 (1-based); match_cnt=3.
2. Non-overlap match: same stream with overlap=0 -> out pulses on bits 6 and 14 only; match_cnt=2.
3. Match limit: overlap=1, limit=2, same stream -> DONE after bit 9; done=1, busy=0; bit 14 is not counted; match_cnt=2.
4. Stop and restart:
   - stop asserted in the cycle of bit 6 -> out=1, match_cnt=1, IDLE next cycle.
   - Then cfg_we while in RUN is ignored, a restart clears match_cnt to 0, and cfg_we in IDLE is accepted.
5. Short pattern and gapped input:
   - len=3, pattern=3'b101, overlap=1, stream 1,0,1,0,1 with in_valid gaps inserted -> match_cnt=2; gaps change nothing.
   - pattern=3'b001 right after ARM needs 3 valid bits before a match; no false hit from the zeroed history.
6. Reset mid-run: drop rst for 3 cycles mid-stream -> all outputs 0 and state IDLE; config returns to pattern=0, len=4, overlap=1, limit=0.
